// File: rtl/band_lut_pkg.sv
// Shared types and default constants for the band-ID lookup RAM controller.
package band_lut_pkg;

    localparam int              ADDR_W_DEF  = 9;
    localparam int              DATA_W_DEF  = 8;
    localparam logic [7:0]      CLR_VAL_DEF = 8'hFF;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        LOOKUP,
        READBACK
    } tag_t;

endpackage

// File: rtl/band_id_lut_ctrl_if.sv
// Config write/readback port of the band-ID lookup controller.
// Handshake: a request transfers in a cycle where cfg_valid && cfg_ready; the master holds
// cfg_we/cfg_addr/cfg_wdata stable while cfg_valid is high and not yet accepted.
// cfg_rvalid is a one-cycle pulse with no backpressure; cfg_rdata holds its last value.
interface band_id_lut_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) ();
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [DATA_W-1:0] cfg_rdata;
    logic              cfg_rvalid;

    modport master (
        output cfg_valid, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_ready, cfg_rdata, cfg_rvalid
    );

    modport slave (
        input  cfg_valid, cfg_we, cfg_addr, cfg_wdata,
        output cfg_ready, cfg_rdata, cfg_rvalid
    );
endinterface

// File: rtl/band_lut_tag_pipe.sv
// RD_LAT-deep shift register carrying the request tag alongside the RAM read latency,
// so tag_o lines up with the data appearing on ram_dout.
module band_lut_tag_pipe
    import band_lut_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o
);
    tag_t pipe_q [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= NONE;
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_o = pipe_q[RD_LAT-1];
endmodule

// File: rtl/band_id_lut_ctrl.sv
// Arbiter/sequencer for the single-port band-ID RAM: lookups, config traffic and bulk clear.
// Optional lookup-drop counter enabled by defining BAND_LUT_DROP_CNT_EN.
module band_id_lut_ctrl
    import band_lut_pkg::*;
#(
    parameter int              ADDR_W  = ADDR_W_DEF,
    parameter int              DATA_W  = DATA_W_DEF,
    parameter int              RD_LAT  = 1,
    parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(CLR_VAL_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic [DATA_W-1:0] band_id,
    output logic              band_id_valid,
    band_id_lut_ctrl_if.slave cfg,
    input  logic              clr_start,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [15:0]       drop_cnt,
    output state_t            dbg_state
);
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              cfg_ready;
    tag_t              tag_in, tag_out;
    logic [DATA_W-1:0] band_id_q, cfg_rdata_q;
    logic              band_id_valid_q, cfg_rvalid_q;

    // Writes are suppressed during rst so an aborted clear stops at the cycle it was hit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_addr  = lk_addr;
        ram_din   = cfg.cfg_wdata;
        cfg_ready = 1'b0;
        tag_in    = NONE;
        case (state_q)
            IDLE: begin
                cfg_ready = !lk_valid && !clr_start && !rst;
                if (lk_valid) begin
                    ram_addr = lk_addr;
                    tag_in   = LOOKUP;
                end else if (cfg.cfg_valid && cfg_ready) begin
                    ram_addr = cfg.cfg_addr;
                    ram_we   = cfg.cfg_we;
                    tag_in   = cfg.cfg_we ? NONE : READBACK;
                end
                if (clr_start) state_d = CLEAR;
            end
            CLEAR: begin
                ram_we   = !rst;
                ram_addr = cnt_q;
                ram_din  = CLR_VAL;
                if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    band_lut_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Output register: one extra cycle after the RAM data appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            band_id_q       <= '0;
            band_id_valid_q <= 1'b0;
            cfg_rdata_q     <= '0;
            cfg_rvalid_q    <= 1'b0;
        end else begin
            band_id_valid_q <= (tag_out == LOOKUP);
            cfg_rvalid_q    <= (tag_out == READBACK);
            if (tag_out == LOOKUP)   band_id_q   <= ram_dout;
            if (tag_out == READBACK) cfg_rdata_q <= ram_dout;
        end
    end

`ifdef BAND_LUT_DROP_CNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (state_q == CLEAR && lk_valid && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

    assign cfg.cfg_ready  = cfg_ready;
    assign cfg.cfg_rdata  = cfg_rdata_q;
    assign cfg.cfg_rvalid = cfg_rvalid_q;
    assign band_id        = band_id_q;
    assign band_id_valid  = band_id_valid_q;
    assign busy           = (state_q == CLEAR);
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_band_id_lut_ctrl.sv
// Bench for band_id_lut_ctrl: behavioural RAM, reference model of memory contents and
// expected responses, directed scenarios followed by randomized traffic.
module tb_band_id_lut_ctrl;
    import band_lut_pkg::*;

    localparam int         ADDR_W  = 9;
    localparam int         DATA_W  = 8;
    localparam int         RD_LAT  = 1;
    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [7:0] CLR_VAL = 8'hFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              lk_valid;
    logic [ADDR_W-1:0] lk_addr;
    logic [DATA_W-1:0] band_id;
    logic              band_id_valid;
    logic              clr_start;
    logic              busy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic [15:0]       drop_cnt;
    state_t            dbg_state;

    band_id_lut_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cfg_if ();

    band_id_lut_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .CLR_VAL(CLR_VAL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lk_valid     (lk_valid),
        .lk_addr      (lk_addr),
        .band_id      (band_id),
        .band_id_valid(band_id_valid),
        .cfg          (cfg_if.slave),
        .clr_start    (clr_start),
        .busy         (busy),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .drop_cnt     (drop_cnt),
        .dbg_state    (dbg_state)
    );

    // ---------------- behavioural RAM ----------------
    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    bit                init_ram = 1'b0;

    function automatic logic [7:0] init_pattern(int i);
        return 8'((i * 37 + 11) & 8'hFF);
    endfunction

    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_pattern(i);
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
        end
        rd_pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_dout = rd_pipe[RD_LAT-1];

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                m_clear;
    int                m_cnt;
    int                m_drop;
    bit                m_acc;
    int                cyc;
    logic [DATA_W-1:0] last_band, last_rdata;
    logic [DATA_W-1:0] exp_lk_q[$];
    int                exp_lk_due_q[$];
    logic [DATA_W-1:0] exp_rb_q[$];
    int                exp_rb_due_q[$];

    int errors = 0;
    int checks = 0;
    int busy_cycles, we_cycles;

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int exp_drop();
`ifdef BAND_LUT_DROP_CNT_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    // One clock cycle with the inputs currently applied: check, advance model, check outputs.
    task automatic tick();
        bit acc;
        bit ev;
        #1;
        acc   = !rst && !m_clear && !lk_valid && !clr_start && cfg_if.cfg_valid;
        m_acc = acc;
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!rst && !m_clear && !lk_valid && !clr_start));
        check("busy", 32'(busy), 32'(m_clear));
        check("state", 32'(dbg_state == CLEAR), 32'(m_clear));
        check("ram_we", 32'(ram_we), 32'(!rst && (m_clear || (acc && cfg_if.cfg_we))));
        if (busy) busy_cycles++;
        if (ram_we) we_cycles++;
        if (!rst && m_clear) begin
            check("clr_addr", 32'(ram_addr), 32'(m_cnt));
            check("clr_din", 32'(ram_din), 32'(CLR_VAL));
        end else if (!rst && lk_valid) begin
            check("lk_ram_addr", 32'(ram_addr), 32'(lk_addr));
        end else if (acc) begin
            check("cfg_ram_addr", 32'(ram_addr), 32'(cfg_if.cfg_addr));
            if (cfg_if.cfg_we) check("cfg_ram_din", 32'(ram_din), 32'(cfg_if.cfg_wdata));
        end

        if (rst) begin
            m_clear = 0;
            m_cnt   = 0;
            m_drop  = 0;
            exp_lk_q.delete();
            exp_lk_due_q.delete();
            exp_rb_q.delete();
            exp_rb_due_q.delete();
            last_band  = '0;
            last_rdata = '0;
        end else if (m_clear) begin
            ref_mem[m_cnt] = CLR_VAL;
            if (lk_valid && m_drop < 65535) m_drop++;
            if (m_cnt == DEPTH - 1) begin
                m_clear = 0;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end else begin
            if (lk_valid) begin
                exp_lk_q.push_back(ref_mem[lk_addr]);
                exp_lk_due_q.push_back(cyc + RD_LAT + 1);
            end else if (acc) begin
                if (cfg_if.cfg_we) begin
                    ref_mem[cfg_if.cfg_addr] = cfg_if.cfg_wdata;
                end else begin
                    exp_rb_q.push_back(ref_mem[cfg_if.cfg_addr]);
                    exp_rb_due_q.push_back(cyc + RD_LAT + 1);
                end
            end
            if (clr_start) m_clear = 1;
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;

        ev = 0;
        if (exp_lk_due_q.size() > 0 && exp_lk_due_q[0] == cyc) begin
            void'(exp_lk_due_q.pop_front());
            last_band = exp_lk_q.pop_front();
            ev = 1;
        end
        check("band_id_valid", 32'(band_id_valid), 32'(ev));
        check("band_id", 32'(band_id), 32'(last_band));

        ev = 0;
        if (exp_rb_due_q.size() > 0 && exp_rb_due_q[0] == cyc) begin
            void'(exp_rb_due_q.pop_front());
            last_rdata = exp_rb_q.pop_front();
            ev = 1;
        end
        check("cfg_rvalid", 32'(cfg_if.cfg_rvalid), 32'(ev));
        check("cfg_rdata", 32'(cfg_if.cfg_rdata), 32'(last_rdata));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop()));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        rst              = 1'b0;
        lk_valid         = 1'b0;
        lk_addr          = '0;
        clr_start        = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_we    = 1'b0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_wdata = '0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_lookup(input logic [ADDR_W-1:0] a);
        lk_valid = 1'b1;
        lk_addr  = a;
        tick();
        lk_valid = 1'b0;
    endtask

    task automatic cfg_req(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_we    = we;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_wdata = d;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic run_clear(input int lk_from, input int lk_to);
        busy_cycles = 0;
        we_cycles   = 0;
        clr_start   = 1'b1;
        tick();
        clr_start   = 1'b0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            lk_valid = (i >= lk_from && i < lk_to);
            lk_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            tick();
        end
        lk_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        set_idle();
        rst      = 1'b1;
        init_ram = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_pattern(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        init_ram   = 1'b0;
        m_clear    = 0;
        m_cnt      = 0;
        m_drop     = 0;
        cyc        = 0;
        last_band  = '0;
        last_rdata = '0;

        check("rst_band_id", 32'(band_id), 32'h0);
        check("rst_band_id_valid", 32'(band_id_valid), 32'h0);
        check("rst_cfg_rdata", 32'(cfg_if.cfg_rdata), 32'h0);
        check("rst_cfg_rvalid", 32'(cfg_if.cfg_rvalid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);

        // Write then immediate lookup of the same address.
        cfg_req(1'b1, 9'h005, 8'h03);
        do_lookup(9'h005);
        drain(4);
        check("lookup_5", 32'(last_band), 32'h03);

        // Lookups hold off a pending config write for 4 cycles, back-to-back results.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_addr  = 9'h0AA;
        cfg_if.cfg_wdata = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            lk_valid = 1'b1;
            lk_addr  = ADDR_W'(5 + i);
            tick();
        end
        lk_valid = 1'b0;
        tick();
        check("cfg_accept_c5", 32'(m_acc), 32'h1);
        cfg_if.cfg_valid = 1'b0;
        do_lookup(9'h0AA);
        drain(4);
        check("lookup_aa", 32'(last_band), 32'h5A);

        // Readback at the top address.
        cfg_req(1'b1, 9'h1FF, 8'hA5);
        cfg_req(1'b0, 9'h1FF, 8'h00);
        drain(4);
        check("readback_1ff", 32'(cfg_if.cfg_rdata), 32'hA5);

        // Full clear with 10 dropped lookups, then spot lookups.
        do_lookup(9'd7);
        run_clear(20, 30);
        check("busy_len", 32'(busy_cycles), 32'd512);
        check("we_len", 32'(we_cycles), 32'd512);
`ifdef BAND_LUT_DROP_CNT_EN
        check("drop_10", 32'(drop_cnt), 32'd10);
`else
        check("drop_0", 32'(drop_cnt), 32'd0);
`endif
        do_lookup(9'd0);
        do_lookup(9'd200);
        do_lookup(9'd511);
        drain(4);
        check("clr_lookup_511", 32'(last_band), 32'hFF);

        // Reset 100 cycles into a clear.
        cfg_req(1'b1, 9'd300, 8'h3C);
        cfg_req(1'b1, 9'd50, 8'h11);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        drain(100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        do_lookup(9'd50);
        drain(4);
        check("abort_50", 32'(last_band), 32'hFF);
        do_lookup(9'd300);
        drain(4);
        check("abort_300", 32'(last_band), 32'h3C);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 4000; i++) begin
            lk_valid  = ($urandom_range(0, 99) < 40);
            lk_addr   = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 15))
                                                   : ADDR_W'($urandom_range(0, DEPTH - 1));
            clr_start = ($urandom_range(0, 999) == 0);
            rst       = ($urandom_range(0, 1999) == 0);
            if (!cfg_if.cfg_valid && $urandom_range(0, 99) < 30) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_we    = $urandom_range(0, 1) == 1;
                cfg_if.cfg_addr  = ADDR_W'($urandom_range(0, 15));
                cfg_if.cfg_wdata = DATA_W'($urandom_range(0, 255));
            end
            tick();
            if (m_acc) cfg_if.cfg_valid = 1'b0;
        end
        set_idle();
        drain(DEPTH + 8);
        check("lk_q_empty", 32'(exp_lk_q.size()), 32'd0);
        check("rb_q_empty", 32'(exp_rb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
